// File: rtl/slot_reel_sequencer_if.sv
// Interface between the game FSM and the reel sequencer.
// The game FSM drives fsm_state; the sequencer returns reel symbols and result flags.
interface slot_reel_sequencer_if #(
    parameter int SYM_W = 3
);
    logic [1:0]       fsm_state;
    logic [SYM_W-1:0] reel0;
    logic [SYM_W-1:0] reel1;
    logic [SYM_W-1:0] reel2;
    logic [2:0]       spinning;
    logic             reels_done;
    logic             win_flag;
    logic             pair_flag;

    // Sequencer side
    modport slave (
        input  fsm_state,
        output reel0, reel1, reel2, spinning, reels_done, win_flag, pair_flag
    );

    // Game FSM side
    modport master (
        output fsm_state,
        input  reel0, reel1, reel2, spinning, reels_done, win_flag, pair_flag
    );
endinterface

// File: rtl/slot_reel_sequencer.sv
// Three-reel slot sequencer: spins the reels at a prescaled rate while the game
// FSM is in RUN, freezes them one by one with a fixed stagger on STOP, then
// evaluates win/pair and holds the result until the game FSM returns to SET.
module slot_reel_sequencer #(
    parameter int SYM_W    = 3,
    parameter int SPIN_DIV = 4,
    parameter int STOP_GAP = 5
) (
    input  logic clk,
    input  logic rst,
    slot_reel_sequencer_if.slave bus
);
    localparam int PW = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
    localparam int GW = (STOP_GAP > 1) ? $clog2(STOP_GAP + 1) : 1;

    localparam logic [1:0] FSM_SET  = 2'b00;
    localparam logic [1:0] FSM_RUN  = 2'b01;
    localparam logic [1:0] FSM_STOP = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        STOP0,
        STOP1,
        EVAL,
        HOLD
    } state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic [GW-1:0]    gap_reg, gap_next;
    logic [2:0]       spin_reg, spin_next;
    logic             done_reg, done_next;
    logic             win_reg, win_next;
    logic             pair_reg, pair_next;
    logic [SYM_W-1:0] reel_reg  [3];
    logic [SYM_W-1:0] reel_next [3];

    logic tick;
    logic eq01, eq12, eq02;
    logic all_eq, two_eq;

    assign tick = (spin_reg != 3'b000) && (presc_reg == PW'(SPIN_DIV - 1));

    assign eq01   = (reel_reg[0] == reel_reg[1]);
    assign eq12   = (reel_reg[1] == reel_reg[2]);
    assign eq02   = (reel_reg[0] == reel_reg[2]);
    assign all_eq = eq01 && eq12;
    // Equality is transitive, so "some pair equal but not all" means exactly two.
    assign two_eq = (eq01 || eq12 || eq02) && !all_eq;

    // Next-state, prescaler, stagger counter and result flags
    always_comb begin
        state_next = state_reg;
        spin_next  = spin_reg;
        gap_next   = gap_reg;
        done_next  = done_reg;
        win_next   = win_reg;
        pair_next  = pair_reg;
        if (spin_reg != 3'b000) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
        end else begin
            presc_next = presc_reg;
        end

        case (state_reg)
            IDLE: begin
                spin_next = 3'b000;
                done_next = 1'b0;
                win_next  = 1'b0;
                pair_next = 1'b0;
                if (bus.fsm_state == FSM_RUN) begin
                    state_next = SPIN;
                    spin_next  = 3'b111;
                    presc_next = '0;
                end
            end
            SPIN: begin
                if (bus.fsm_state == FSM_SET) begin
                    state_next = IDLE;
                    spin_next  = 3'b000;
                end else if (bus.fsm_state == FSM_STOP) begin
                    state_next = STOP0;
                    spin_next  = 3'b110;
                    gap_next   = '0;
                end
            end
            STOP0: begin
                if (bus.fsm_state == FSM_SET) begin
                    state_next = IDLE;
                    spin_next  = 3'b000;
                end else if (gap_reg == GW'(STOP_GAP - 1)) begin
                    state_next = STOP1;
                    spin_next  = 3'b100;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            STOP1: begin
                if (bus.fsm_state == FSM_SET) begin
                    state_next = IDLE;
                    spin_next  = 3'b000;
                end else if (gap_reg == GW'(STOP_GAP - 1)) begin
                    state_next = EVAL;
                    spin_next  = 3'b000;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            EVAL: begin
                if (bus.fsm_state == FSM_SET) begin
                    state_next = IDLE;
                end else begin
                    state_next = HOLD;
                    done_next  = 1'b1;
                    win_next   = all_eq;
                    pair_next  = two_eq;
                end
            end
            HOLD: begin
                if (bus.fsm_state == FSM_SET) begin
                    state_next = IDLE;
                    done_next  = 1'b0;
                    win_next   = 1'b0;
                    pair_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                spin_next  = 3'b000;
            end
        endcase
    end

    // Control and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            gap_reg   <= '0;
            spin_reg  <= 3'b000;
            done_reg  <= 1'b0;
            win_reg   <= 1'b0;
            pair_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            gap_reg   <= gap_next;
            spin_reg  <= spin_next;
            done_reg  <= done_next;
            win_reg   <= win_next;
            pair_reg  <= pair_next;
        end
    end

    // Per-reel stepping. A reel advances only if it is still spinning after
    // this edge, so a reel frozen on a tick edge keeps its pre-tick symbol.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_reel
            localparam logic [SYM_W-1:0] STEP = (gi == 0) ? SYM_W'(1) :
                                                (gi == 1) ? SYM_W'(3) :
                                                {SYM_W{1'b1}};

            assign reel_next[gi] = (spin_next[gi] && tick) ? reel_reg[gi] + STEP
                                                           : reel_reg[gi];

            // Reel symbol register
            always_ff @(posedge clk) begin
                if (rst) begin
                    reel_reg[gi] <= SYM_W'(gi);
                end else begin
                    reel_reg[gi] <= reel_next[gi];
                end
            end
        end
    endgenerate

    assign bus.reel0      = reel_reg[0];
    assign bus.reel1      = reel_reg[1];
    assign bus.reel2      = reel_reg[2];
    assign bus.spinning   = spin_reg;
    assign bus.reels_done = done_reg;
    assign bus.win_flag   = win_reg;
    assign bus.pair_flag  = pair_reg;
endmodule

// File: tb/tb_slot_reel_sequencer.sv
// Directed bench for slot_reel_sequencer with default parameters.
module tb_slot_reel_sequencer;
    localparam logic [1:0] SET  = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STOP = 2'b10;
    localparam logic [1:0] WIN  = 2'b11;
    localparam int DIV = 4;
    localparam int GAP = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   obs_win, obs_pair, obs_none;
    logic [2:0] m0, m1, m2;

    slot_reel_sequencer_if #(.SYM_W(3)) bus ();

    slot_reel_sequencer #(.SYM_W(3), .SPIN_DIV(DIV), .STOP_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reels(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                             input logic [2:0] e2);
        chk({tag, "_r0"}, 32'(bus.reel0), 32'(e0));
        chk({tag, "_r1"}, 32'(bus.reel1), 32'(e1));
        chk({tag, "_r2"}, 32'(bus.reel2), 32'(e2));
    endtask

    task automatic chk_idle_flags(input string tag);
        chk({tag, "_spin"}, 32'(bus.spinning), 32'(3'b000));
        chk({tag, "_done"}, 32'(bus.reels_done), 32'(1'b0));
        chk({tag, "_win"},  32'(bus.win_flag), 32'(1'b0));
        chk({tag, "_pair"}, 32'(bus.pair_flag), 32'(1'b0));
    endtask

    initial begin
        int k;
        int t0, t1, t2;
        logic ew, ep;
        checks = 0; errors = 0;
        obs_win = 0; obs_pair = 0; obs_none = 0;

        // 1. Reset with RUN present: no spinning, reset symbols
        rst = 1'b1;
        bus.fsm_state = RUN;
        step();
        step();
        $display("step reset: reels %0d/%0d/%0d", bus.reel0, bus.reel1, bus.reel2);
        chk_reels("rst", 3'd0, 3'd1, 3'd2);
        chk_idle_flags("rst");

        // 2. Spin rate: 8 cycles after SPIN entry -> 2 ticks
        rst = 1'b0;
        bus.fsm_state = SET;
        step();
        step();
        bus.fsm_state = RUN;
        step();
        chk("spin_entry", 32'(bus.spinning), 32'(3'b111));
        repeat (8) step();
        $display("step spin8: reels %0d/%0d/%0d", bus.reel0, bus.reel1, bus.reel2);
        chk_reels("spin8", 3'd2, 3'd7, 3'd0);
        chk("spin8_spin", 32'(bus.spinning), 32'(3'b111));

        // 3. Staggered stop; STOP driven here, reels_done 12 edges later
        bus.fsm_state = STOP;
        step();
        chk("stop_e0_spin", 32'(bus.spinning), 32'(3'b110));
        chk("stop_e0_r0", 32'(bus.reel0), 32'(3'd2));
        repeat (4) step();
        chk("stop_e4_spin", 32'(bus.spinning), 32'(3'b110));
        step();
        chk("stop_e5_spin", 32'(bus.spinning), 32'(3'b100));
        repeat (5) step();
        chk("stop_e10_spin", 32'(bus.spinning), 32'(3'b000));
        chk("stop_e10_done", 32'(bus.reels_done), 32'(1'b0));
        step();
        $display("step stop: done %0b reels %0d/%0d/%0d win %0b pair %0b", bus.reels_done,
                 bus.reel0, bus.reel1, bus.reel2, bus.win_flag, bus.pair_flag);
        chk("stop_e11_done", 32'(bus.reels_done), 32'(1'b1));
        chk_reels("stop", 3'd2, 3'd2, 3'd6);
        chk("stop_win", 32'(bus.win_flag), 32'(1'b0));
        chk("stop_pair", 32'(bus.pair_flag), 32'(1'b1));
        bus.fsm_state = SET;
        step();
        chk_idle_flags("set_after_stop");
        chk_reels("set_after_stop", 3'd2, 3'd2, 3'd6);

        // 5. Abort in STOP0, then restart with a cleared prescaler
        bus.fsm_state = RUN;
        step();
        step();
        step();
        bus.fsm_state = STOP;
        step();
        step();
        step();
        bus.fsm_state = SET;
        step();
        $display("step abort: spin %b reels %0d/%0d/%0d", bus.spinning, bus.reel0, bus.reel1,
                 bus.reel2);
        chk_idle_flags("abort");
        chk_reels("abort", 3'd2, 3'd5, 3'd5);
        bus.fsm_state = RUN;
        step();
        repeat (3) step();
        chk_reels("restart3", 3'd2, 3'd5, 3'd5);
        step();
        chk_reels("restart4", 3'd3, 3'd0, 3'd4);
        bus.fsm_state = SET;
        step();

        // 6a. Reset in STOP1
        bus.fsm_state = RUN;
        step();
        bus.fsm_state = STOP;
        step();
        repeat (6) step();
        chk("pre_rst_spin", 32'(bus.spinning), 32'(3'b100));
        rst = 1'b1;
        step();
        $display("step rst_stop1: reels %0d/%0d/%0d", bus.reel0, bus.reel1, bus.reel2);
        chk_reels("rst_stop1", 3'd0, 3'd1, 3'd2);
        chk_idle_flags("rst_stop1");
        rst = 1'b0;
        bus.fsm_state = SET;
        step();
        // STOP seen in IDLE is ignored
        bus.fsm_state = STOP;
        step();
        step();
        chk_idle_flags("idle_stop");
        bus.fsm_state = SET;
        step();

        // 4. Sweep RUN duration against the tick-count model
        m0 = 3'd0; m1 = 3'd1; m2 = 3'd2;
        for (int n = 1; n <= 64; n++) begin
            bus.fsm_state = RUN;
            step();
            repeat (n) step();
            bus.fsm_state = STOP;
            step();
            k = 0;
            while (!bus.reels_done && k < 30) begin
                step();
                k++;
            end
            chk("sweep_latency", 32'(k), 32'(2 * GAP + 1));
            // reel0 ticks before the STOP edge, reel1/reel2 keep going GAP/2*GAP edges more
            t0 = n / DIV;
            t1 = (n + GAP) / DIV;
            t2 = (n + 2 * GAP) / DIV;
            m0 = m0 + 3'(t0);
            m1 = m1 + 3'(3 * t1);
            m2 = m2 - 3'(t2);
            ew = (m0 == m1) && (m1 == m2);
            ep = !ew && ((m0 == m1) || (m1 == m2) || (m0 == m2));
            $display("sweep n=%0d: reels %0d/%0d/%0d win %0b pair %0b", n, bus.reel0,
                     bus.reel1, bus.reel2, bus.win_flag, bus.pair_flag);
            chk_reels("sweep", m0, m1, m2);
            chk("sweep_win", 32'(bus.win_flag), 32'(ew));
            chk("sweep_pair", 32'(bus.pair_flag), 32'(ep));
            if (bus.win_flag) obs_win++;
            else if (bus.pair_flag) obs_pair++;
            else obs_none++;
            if (bus.win_flag) begin
                // 6b. Game FSM goes to WIN; RUN in HOLD is ignored
                bus.fsm_state = WIN;
                repeat (3) step();
                chk("hold_win_done", 32'(bus.reels_done), 32'(1'b1));
                chk("hold_win_flag", 32'(bus.win_flag), 32'(1'b1));
                bus.fsm_state = RUN;
                repeat (2) step();
                chk("hold_run_flag", 32'(bus.win_flag), 32'(1'b1));
                chk("hold_run_spin", 32'(bus.spinning), 32'(3'b000));
            end
            bus.fsm_state = SET;
            step();
            chk("sweep_set_win", 32'(bus.win_flag), 32'(1'b0));
            chk("sweep_set_done", 32'(bus.reels_done), 32'(1'b0));
        end
        chk("hit_win", 32'(obs_win > 0), 32'(1));
        chk("hit_pair", 32'(obs_pair > 0), 32'(1));
        chk("hit_none", 32'(obs_none > 0), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
